addsub_pipe: RTL and testbench

Parametrised, pipelined add/subtract unit with per-transaction mode select, carry/borrow and signed-overflow flags, and a full valid/ready handshake on both sides. It is the successor to the single-cycle subtractor in the priority calculator. The WIDTH-bit carry chain is split into STAGES registered slices, so wide operands close timing at one result per cycle. Downstream backpressure stalls the pipe without loss, and bubbles collapse.

---
 rtl/addsub_pkg.sv | 11 +
 rtl/addsub_slice.sv | 71 +++++++
 rtl/addsub_pipe.sv | 86 ++++++++
 tb/tb_addsub_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the pipelined add/subtract unit.
package addsub_pkg;

    typedef enum logic {OP_SUB = 1'b0, OP_ADD = 1'b1} op_mode_e;

    // Carry for add, borrow for subtract (a borrow is the inverted carry-out of a + ~b + 1).
    function automatic logic carry_flag(input op_mode_e m, input logic cout);
        return (m == OP_ADD) ? cout : !cout;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: one registered carry-chain slice; consumes the low SLICE bits of the
// forwarded operands and shifts its result slice in from the top of the result word.
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_ready,
    input  op_mode_e         i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_cin,
    output logic             o_valid,
    output op_mode_e         o_mode,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout,
    output logic             o_ovf
);

    logic             r_valid;
    op_mode_e         r_mode;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;
    logic [SLICE:0]   w_sum;
    logic             w_msb_cin;

    assign w_sum     = {1'b0, i_a[SLICE-1:0]} + {1'b0, i_b[SLICE-1:0]} + (SLICE+1)'(i_cin);
    // Carry into the slice MSB, recovered from the sum bit; ovf = that carry xor carry-out.
    assign w_msb_cin = w_sum[SLICE-1] ^ i_a[SLICE-1] ^ i_b[SLICE-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_mode  <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (i_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_mode <= i_mode;
                r_a    <= i_a >> SLICE;
                r_b    <= i_b >> SLICE;
                r_res  <= (i_res >> SLICE) | (WIDTH'(w_sum[SLICE-1:0]) << (WIDTH - SLICE));
                r_cout <= w_sum[SLICE];
                r_ovf  <= w_msb_cin ^ w_sum[SLICE];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_res   = r_res;
    assign o_cout  = r_cout;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: STAGES-deep pipelined add/subtract with carry/borrow and signed-overflow
// flags; per-stage valid/ready lets bubbles collapse under downstream backpressure.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             op_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res,
    output logic             res_carry,
    output logic             res_ovf
);

    localparam int SLICE = WIDTH / STAGES;

    typedef struct packed {
        logic             valid;
        op_mode_e         mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
    } stage_t;

    stage_t        w_stg [STAGES+1];
    logic [STAGES:0] w_rdy;

    // Entry point: subtract feeds ~b with carry-in 1.
    assign w_stg[0] = '{valid: op_valid, mode: op_mode_e'(op_mode), a: op_a,
                        b: op_mode ? op_b : ~op_b, res: '0, carry: !op_mode, ovf: 1'b0};

    always_comb begin
        w_rdy[STAGES] = res_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            w_rdy[k] = !w_stg[k+1].valid || w_rdy[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_valid;
        op_mode_e         w_mode;
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_res;
        logic             w_cout;
        logic             w_ovf;

        addsub_slice #(.WIDTH(WIDTH), .SLICE(SLICE)) u_slice (
            .clk     (clk),
            .rst     (rst),
            .i_valid (w_stg[k].valid),
            .i_ready (w_rdy[k]),
            .i_mode  (w_stg[k].mode),
            .i_a     (w_stg[k].a),
            .i_b     (w_stg[k].b),
            .i_res   (w_stg[k].res),
            .i_cin   (w_stg[k].carry),
            .o_valid (w_valid),
            .o_mode  (w_mode),
            .o_a     (w_a),
            .o_b     (w_b),
            .o_res   (w_res),
            .o_cout  (w_cout),
            .o_ovf   (w_ovf)
        );

        assign w_stg[k+1] = '{valid: w_valid, mode: w_mode, a: w_a, b: w_b,
                              res: w_res, carry: w_cout, ovf: w_ovf};
    end

    assign op_ready  = w_rdy[0] && !rst;
    assign res_valid = w_stg[STAGES].valid;
    assign res       = w_stg[STAGES].res;
    assign res_carry = carry_flag(w_stg[STAGES].mode, w_stg[STAGES].carry);
    assign res_ovf   = w_stg[STAGES].ovf;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed vector table plus scoreboarded streams for addsub_pipe
// (WIDTH=8, STAGES=2), covering stalls, bubble collapse and mid-flight reset.
module tb_addsub_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic         op_mode;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res;
    logic         res_carry;
    logic         res_ovf;

    int           n_pass  = 0;
    int           n_total = 0;
    int           n_res   = 0;
    bit           sb_on   = 1'b0;
    logic [W+1:0] q[$];

    typedef struct {
        logic         m;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } vec_t;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_mode   (op_mode),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .res_carry (res_carry),
        .res_ovf   (res_ovf)
    );

    // Reference: {res, carry/borrow, ovf} from plain arithmetic.
    function automatic logic [W+1:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] f;
        logic       c;
        logic       v;
        if (m) begin
            f = {1'b0, a} + {1'b0, b};
            c = f[W];
            v = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
        end else begin
            f = {1'b0, a} - {1'b0, b};
            c = a < b;
            v = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
        end
        return {f[W-1:0], c, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) q.delete();
        else if (sb_on) begin
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected result: got %h, required none", {res, res_carry, res_ovf});
                end else begin
                    check("stream", 32'({res, res_carry, res_ovf}), 32'(q.pop_front()));
                    n_res++;
                end
            end
            if (op_valid && op_ready) q.push_back(model(op_mode, op_a, op_b));
        end
    end

    // Called just after a rising edge; holds the op until accepted, returns just after that edge.
    task automatic send(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 1'b0;
        op_valid = 1'b1; op_mode = m; op_a = a; op_b = b;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = op_ready;
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL send timeout: got op_ready=0, required 1 within 40 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain queue empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        vec_t         vt[8];
        logic [W+1:0] e1;
        int           n_sent;
        int           n0;
        bit           acc;

        vt[0] = '{1'b0, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vt[1] = '{1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vt[2] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vt[3] = '{1'b1, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        vt[4] = '{1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vt[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vt[7] = '{1'b0, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

        rst = 1'b1; op_valid = 1'b0; op_mode = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'({res, res_carry, res_ovf}), 32'd0);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset op_ready", 32'(op_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("op_ready after reset", 32'(op_ready), 32'd1);

        // Directed vectors: exact 2-cycle latency and flag values.
        foreach (vt[i]) begin
            @(posedge clk); #1;
            op_valid = 1'b1; op_mode = vt[i].m; op_a = vt[i].a; op_b = vt[i].b;
            check("vec op_ready", 32'(op_ready), 32'd1);
            @(posedge clk); #1;
            op_valid = 1'b0;
            check("vec early res_valid", 32'(res_valid), 32'd0);
            @(posedge clk); #1;
            check("vec res_valid", 32'(res_valid), 32'd1);
            check("vec result", 32'({res, res_carry, res_ovf}), 32'({vt[i].r, vt[i].c, vt[i].v}));
        end
        @(posedge clk); #1;

        // Back-to-back stream at full rate.
        sb_on = 1'b1;
        n_res = 0;
        for (int i = 0; i < 100; i++) begin
            op_valid = 1'b1; op_mode = 1'($urandom); op_a = W'($urandom); op_b = W'($urandom);
            check("b2b op_ready", 32'(op_ready), 32'd1);
            if (i >= 2) check("b2b res_valid", 32'(res_valid), 32'd1);
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        drain();
        check("b2b result count", 32'(n_res), 32'd100);

        // Full stall: two accepted, third refused, head result held stable.
        n_res = 0;
        res_ready = 1'b0;
        op_valid = 1'b1; op_mode = 1'b1; op_a = 8'h7F; op_b = 8'h01;
        e1 = model(1'b1, 8'h7F, 8'h01);
        @(posedge clk); #1;
        op_mode = 1'b0; op_a = 8'h10; op_b = 8'h20;
        check("stall second accept", 32'(op_ready), 32'd1);
        @(posedge clk); #1;
        op_mode = 1'b1; op_a = 8'h33; op_b = 8'h44;
        for (int i = 0; i < 3; i++) begin
            check("stall op_ready", 32'(op_ready), 32'd0);
            check("stall res_valid", 32'(res_valid), 32'd1);
            check("stall hold", 32'({res, res_carry, res_ovf}), 32'(e1));
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        send(1'b1, 8'h33, 8'h44);
        send(1'b0, 8'h01, 8'h02);
        drain();
        check("stall result count", 32'(n_res), 32'd4);

        // Bubble collapse: stalled output with empty stage 0 still accepts.
        res_ready = 1'b0;
        send(1'b0, 8'hA0, 8'h0B);
        @(posedge clk); #1;
        check("collapse res_valid", 32'(res_valid), 32'd1);
        check("collapse op_ready", 32'(op_ready), 32'd1);
        res_ready = 1'b1;
        drain();

        // Random backpressure and random op gaps.
        n_res = 0; n_sent = 0; acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!op_valid || acc) begin
                op_valid = ($urandom_range(9) < 6);
                op_mode = 1'($urandom); op_a = W'($urandom); op_b = W'($urandom);
            end
            res_ready = 1'($urandom);
            @(negedge clk);
            acc = op_valid && op_ready;
            if (acc) n_sent++;
            @(posedge clk); #1;
        end
        op_valid = 1'b0; res_ready = 1'b1;
        drain();
        check("random result count", 32'(n_res), 32'(n_sent));

        // Reset with two ops in flight discards both.
        res_ready = 1'b0;
        send(1'b1, 8'h11, 8'h22);
        send(1'b0, 8'h55, 8'h66);
        check("flight res_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst outputs", 32'({res, res_carry, res_ovf}), 32'd0);
        check("midrst res_valid", 32'(res_valid), 32'd0);
        check("midrst op_ready", 32'(op_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("op_ready after midrst", 32'(op_ready), 32'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no ghost result", 32'(res_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
